// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the memory bus arbiter slice.
//   msize_t     : log2 transfer size in bytes (0..3)
//   strobe_t    : byte write enables, all-zero means read
//   arb_state_t : arbiter transaction phase
//   owner_t     : which upstream port owns the current transaction
package mem_bus_arbiter_pkg;

   typedef logic [2:0] msize_t;
   typedef logic [7:0] strobe_t;

   // Instruction fetches are always 4-byte words.
   localparam msize_t MSIZE4 = 3'b010;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } arb_state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_D    = 2'd2
   } owner_t;

endpackage

// File: rtl/mem_bus_arbiter_arb_prio_pick.sv
// Grant selection between the fetch and data ports, with a starvation guard.
// Data wins ties; once it has won MAX_D_STREAK ties in a row, fetch is forced.
// The guard is kept as a credit down-counter: credits left = MAX_D_STREAK - streak,
// so terminal count (zero credits) means fetch must be granted next.
// Ports:
//   clk, reset       clock, async active-high reset
//   grant_en         arbiter is in IDLE and may issue a grant this cycle
//   i_valid, d_valid upstream request valids
//   grant_if,grant_d one-hot (or zero) grant decision, combinational
module mem_bus_arbiter_arb_prio_pick #(
   parameter int MAX_D_STREAK = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic grant_en,
   input  logic i_valid,
   input  logic d_valid,
   output logic grant_if,
   output logic grant_d
);

   localparam int CW = $clog2(MAX_D_STREAK + 1);

   logic [CW-1:0] d_credit;
   logic          d_credit_tc;

   assign d_credit_tc = (d_credit == '0);

   always_comb begin
      grant_d  = d_valid && !(i_valid && d_credit_tc);
      grant_if = i_valid && !grant_d;
   end

   // Credits only fall on a data grant that made fetch wait; a data grant
   // can never occur with fetch waiting at zero credits, so no underflow.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         d_credit <= CW'(MAX_D_STREAK);
      end else if (grant_en && (grant_d || grant_if)) begin
         if (grant_d && i_valid)
            d_credit <= d_credit - CW'(1);
         else
            d_credit <= CW'(MAX_D_STREAK);
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one downstream memory port between the fetch bus (IF) and the data bus.
// One request is granted in IDLE, latched into the m_req_* registers and held
// until the downstream port accepts the address; responses are routed back to
// the owner only.
// Ports:
//   clk, reset                 clock, async active-high reset
//   i_req_* / i_*_ok / i_data  fetch port (32-bit instruction word back)
//   d_req_* / d_*_ok / d_data  data port (full-width read data back)
//   m_req_* / m_*_ok / m_rdata downstream memory port
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no transaction; grant and latch a request (one bubble cycle)
// ADDR  | m_req_valid high, waiting for m_addr_ok
// DATA  | address accepted, waiting for m_data_ok
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int ADDR_W       = 64,
   parameter int DATA_W       = 64,
   parameter int MAX_D_STREAK = 4
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              i_req_valid,
   input  logic [ADDR_W-1:0] i_req_addr,
   output logic              i_addr_ok,
   output logic              i_data_ok,
   output logic [31:0]       i_data,

   input  logic              d_req_valid,
   input  logic [ADDR_W-1:0] d_req_addr,
   input  logic [2:0]        d_req_size,
   input  logic [7:0]        d_req_strobe,
   input  logic [DATA_W-1:0] d_req_data,
   output logic              d_addr_ok,
   output logic              d_data_ok,
   output logic [DATA_W-1:0] d_data,

   output logic              m_req_valid,
   output logic [ADDR_W-1:0] m_req_addr,
   output logic [2:0]        m_req_size,
   output logic [7:0]        m_req_strobe,
   output logic [DATA_W-1:0] m_req_data,
   input  logic              m_addr_ok,
   input  logic              m_data_ok,
   input  logic [DATA_W-1:0] m_rdata
);

   arb_state_t state;
   owner_t     owner;
   logic       grant_if;
   logic       grant_d;

   mem_bus_arbiter_arb_prio_pick #(
      .MAX_D_STREAK (MAX_D_STREAK)
   ) u_prio_pick (
      .clk      (clk),
      .reset    (reset),
      .grant_en (state == IDLE),
      .i_valid  (i_req_valid),
      .d_valid  (d_req_valid),
      .grant_if (grant_if),
      .grant_d  (grant_d)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         owner        <= OWN_NONE;
         m_req_valid  <= 1'b0;
         m_req_addr   <= '0;
         m_req_size   <= '0;
         m_req_strobe <= '0;
         m_req_data   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_d) begin
                  owner        <= OWN_D;
                  m_req_addr   <= d_req_addr;
                  m_req_size   <= d_req_size;
                  m_req_strobe <= d_req_strobe;
                  m_req_data   <= d_req_data;
                  m_req_valid  <= 1'b1;
                  state        <= ADDR;
               end else if (grant_if) begin
                  owner        <= OWN_IF;
                  m_req_addr   <= i_req_addr;
                  m_req_size   <= MSIZE4;
                  m_req_strobe <= '0;
                  m_req_data   <= '0;
                  m_req_valid  <= 1'b1;
                  state        <= ADDR;
               end
            end
            ADDR: begin
               // m_data_ok before the address is accepted is not a real completion.
               if (m_addr_ok) begin
                  m_req_valid <= 1'b0;
                  if (m_data_ok) begin
                     owner <= OWN_NONE;
                     state <= IDLE;
                  end else begin
                     state <= DATA;
                  end
               end
            end
            DATA: begin
               if (m_data_ok) begin
                  owner <= OWN_NONE;
                  state <= IDLE;
               end
            end
            default: begin
               owner <= OWN_NONE;
               state <= IDLE;
            end
         endcase
      end
   end

   // Responses follow the downstream handshakes in the same cycle. An owner
   // that dropped its valid still lets the downstream transfer finish but
   // receives no pulses.
   logic addr_phase;
   logic data_phase;
   logic i_own;
   logic d_own;

   always_comb begin
      addr_phase = (state == ADDR) && m_addr_ok;
      data_phase = m_data_ok && ((state == DATA) || addr_phase);
      i_own      = (owner == OWN_IF) && i_req_valid;
      d_own      = (owner == OWN_D) && d_req_valid;

      i_addr_ok  = addr_phase && i_own;
      i_data_ok  = data_phase && i_own;
      d_addr_ok  = addr_phase && d_own;
      d_data_ok  = data_phase && d_own;

      // Fetch gets the 32-bit half selected by the latched address.
      i_data     = '0;
      if (i_data_ok)
         i_data = m_req_addr[2] ? m_rdata[32 +: 32] : m_rdata[31:0];
      d_data     = d_data_ok ? m_rdata : '0;
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

   logic        clk;
   logic        reset;
   logic        i_req_valid;
   logic [63:0] i_req_addr;
   logic        i_addr_ok;
   logic        i_data_ok;
   logic [31:0] i_data;
   logic        d_req_valid;
   logic [63:0] d_req_addr;
   logic [2:0]  d_req_size;
   logic [7:0]  d_req_strobe;
   logic [63:0] d_req_data;
   logic        d_addr_ok;
   logic        d_data_ok;
   logic [63:0] d_data;
   logic        m_req_valid;
   logic [63:0] m_req_addr;
   logic [2:0]  m_req_size;
   logic [7:0]  m_req_strobe;
   logic [63:0] m_req_data;
   logic        m_addr_ok;
   logic        m_data_ok;
   logic [63:0] m_rdata;

   int checks = 0;
   int errors = 0;

   mem_bus_arbiter #(
      .ADDR_W       (64),
      .DATA_W       (64),
      .MAX_D_STREAK (4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .i_req_valid  (i_req_valid),
      .i_req_addr   (i_req_addr),
      .i_addr_ok    (i_addr_ok),
      .i_data_ok    (i_data_ok),
      .i_data       (i_data),
      .d_req_valid  (d_req_valid),
      .d_req_addr   (d_req_addr),
      .d_req_size   (d_req_size),
      .d_req_strobe (d_req_strobe),
      .d_req_data   (d_req_data),
      .d_addr_ok    (d_addr_ok),
      .d_data_ok    (d_data_ok),
      .d_data       (d_data),
      .m_req_valid  (m_req_valid),
      .m_req_addr   (m_req_addr),
      .m_req_size   (m_req_size),
      .m_req_strobe (m_req_strobe),
      .m_req_data   (m_req_data),
      .m_addr_ok    (m_addr_ok),
      .m_data_ok    (m_data_ok),
      .m_rdata      (m_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full transaction starting from IDLE with the requests already driven:
   // bubble, ADDR with m_addr_ok, one DATA cycle with m_data_ok.
   task automatic run_txn(input string tag, input logic exp_if,
                          input logic [63:0] exp_addr, input logic [63:0] rdata);
      logic [31:0] exp_word;
      exp_word = exp_addr[2] ? rdata[63:32] : rdata[31:0];
      chk({tag, "_bubble"}, m_req_valid, 1'b0);
      tick();
      chk({tag, "_valid"}, m_req_valid, 1'b1);
      chk({tag, "_addr"}, m_req_addr, exp_addr);
      m_addr_ok = 1'b1;
      #1;
      chk({tag, "_i_addr_ok"}, i_addr_ok, exp_if);
      chk({tag, "_d_addr_ok"}, d_addr_ok, !exp_if);
      tick();
      m_addr_ok = 1'b0;
      m_data_ok = 1'b1;
      m_rdata   = rdata;
      #1;
      chk({tag, "_i_data_ok"}, i_data_ok, exp_if);
      chk({tag, "_d_data_ok"}, d_data_ok, !exp_if);
      if (exp_if)
         chk({tag, "_i_data"}, i_data, exp_word);
      else
         chk({tag, "_d_data"}, d_data, rdata);
      tick();
      m_data_ok = 1'b0;
   endtask

   initial begin
      reset        = 1'b1;
      i_req_valid  = 1'b1;
      i_req_addr   = 64'h0;
      d_req_valid  = 1'b0;
      d_req_addr   = 64'h0;
      d_req_size   = 3'd0;
      d_req_strobe = 8'h0;
      d_req_data   = 64'h0;
      m_addr_ok    = 1'b1;
      m_data_ok    = 1'b1;
      m_rdata      = 64'hFFFF_FFFF_FFFF_FFFF;

      // Reset state, with handshakes forced high to show outputs stay low.
      tick();
      tick();
      chk("rst_m_req_valid", m_req_valid, 1'b0);
      chk("rst_m_req_addr", m_req_addr, 64'h0);
      chk("rst_i_addr_ok", i_addr_ok, 1'b0);
      chk("rst_i_data_ok", i_data_ok, 1'b0);
      chk("rst_d_data_ok", d_data_ok, 1'b0);
      i_req_valid = 1'b0;
      m_addr_ok   = 1'b0;
      m_data_ok   = 1'b0;
      m_rdata     = 64'h0;
      reset       = 1'b0;
      tick();

      // Fetch read with a two-cycle data latency, upper word selected.
      i_req_valid = 1'b1;
      i_req_addr  = 64'h8000_0004;
      #1;
      chk("a_bubble", m_req_valid, 1'b0);
      tick();
      chk("a_valid", m_req_valid, 1'b1);
      chk("a_addr", m_req_addr, 64'h8000_0004);
      chk("a_size", m_req_size, 3'b010);
      chk("a_strobe", m_req_strobe, 8'h0);
      chk("a_wdata", m_req_data, 64'h0);
      m_addr_ok = 1'b1;
      #1;
      chk("a_i_addr_ok", i_addr_ok, 1'b1);
      chk("a_i_data_ok_early", i_data_ok, 1'b0);
      tick();
      m_addr_ok = 1'b0;
      #1;
      chk("a_valid_dropped", m_req_valid, 1'b0);
      chk("a_i_data_ok_wait", i_data_ok, 1'b0);
      tick();
      m_data_ok = 1'b1;
      m_rdata   = 64'h1111_2222_3333_4444;
      #1;
      chk("a_i_data_ok", i_data_ok, 1'b1);
      chk("a_i_data", i_data, 32'h1111_2222);
      chk("a_d_data_ok", d_data_ok, 1'b0);
      tick();
      m_data_ok   = 1'b0;
      i_req_valid = 1'b0;
      #1;
      chk("a_i_data_ok_once", i_data_ok, 1'b0);
      // Stray m_data_ok in IDLE produces no pulse.
      m_data_ok = 1'b1;
      #1;
      chk("stray_i_data_ok", i_data_ok, 1'b0);
      chk("stray_d_data_ok", d_data_ok, 1'b0);
      m_data_ok = 1'b0;
      tick();

      // Owner drops valid mid-transaction: completes downstream, no pulses.
      i_req_valid = 1'b1;
      i_req_addr  = 64'h1000;
      tick();
      i_req_valid = 1'b0;
      m_addr_ok   = 1'b1;
      m_data_ok   = 1'b1;
      #1;
      chk("drop_i_addr_ok", i_addr_ok, 1'b0);
      chk("drop_i_data_ok", i_data_ok, 1'b0);
      tick();
      m_addr_ok = 1'b0;
      m_data_ok = 1'b0;
      #1;
      chk("drop_idle", m_req_valid, 1'b0);
      tick();

      // Both valid: data first; after four data wins fetch is forced: D,D,D,D,IF,D.
      i_req_valid  = 1'b1;
      i_req_addr   = 64'h1000;
      d_req_valid  = 1'b1;
      d_req_addr   = 64'h2000;
      d_req_size   = 3'd3;
      d_req_strobe = 8'h0;
      d_req_data   = 64'h0;
      #1;
      run_txn("s1", 1'b0, 64'h2000, 64'h0101_0101_0202_0202);
      run_txn("s2", 1'b0, 64'h2000, 64'h0303_0303_0404_0404);
      run_txn("s3", 1'b0, 64'h2000, 64'h0505_0505_0606_0606);
      run_txn("s4", 1'b0, 64'h2000, 64'h0707_0707_0808_0808);
      run_txn("s5", 1'b1, 64'h1000, 64'hAAAA_BBBB_CCCC_DDDD);
      i_req_valid = 1'b0;
      #1;
      run_txn("s6", 1'b0, 64'h2000, 64'h0909_0909_0A0A_0A0A);
      d_req_valid = 1'b0;
      tick();

      // Address and data accepted together: straight back to IDLE.
      d_req_valid = 1'b1;
      d_req_addr  = 64'h3008;
      tick();
      m_addr_ok = 1'b1;
      m_data_ok = 1'b1;
      m_rdata   = 64'h5555_6666_7777_8888;
      #1;
      chk("same_d_addr_ok", d_addr_ok, 1'b1);
      chk("same_d_data_ok", d_data_ok, 1'b1);
      chk("same_d_data", d_data, 64'h5555_6666_7777_8888);
      chk("same_i_data_ok", i_data_ok, 1'b0);
      tick();
      m_addr_ok = 1'b0;
      #1;
      // Still holding m_data_ok: a DATA state would pulse again, IDLE must not.
      chk("same_idle_no_pulse", d_data_ok, 1'b0);
      chk("same_idle_valid", m_req_valid, 1'b0);
      d_req_valid = 1'b0;
      m_data_ok   = 1'b0;
      tick();

      // Byte write held stable while upstream fields change.
      d_req_valid  = 1'b1;
      d_req_addr   = 64'h4000;
      d_req_size   = 3'd0;
      d_req_strobe = 8'h10;
      d_req_data   = 64'h0000_00AB_0000_0000;
      tick();
      d_req_addr   = 64'h9999;
      d_req_data   = 64'hFFFF;
      d_req_strobe = 8'hFF;
      m_data_ok    = 1'b1;
      #1;
      chk("w_early_data_ok", d_data_ok, 1'b0);
      chk("w_early_addr_ok", d_addr_ok, 1'b0);
      tick();
      m_data_ok = 1'b0;
      chk("w_valid", m_req_valid, 1'b1);
      chk("w_addr", m_req_addr, 64'h4000);
      chk("w_size", m_req_size, 3'd0);
      chk("w_strobe", m_req_strobe, 8'h10);
      chk("w_wdata", m_req_data, 64'h0000_00AB_0000_0000);
      m_addr_ok = 1'b1;
      #1;
      chk("w_d_addr_ok", d_addr_ok, 1'b1);
      tick();
      m_addr_ok = 1'b0;
      m_data_ok = 1'b1;
      #1;
      chk("w_d_data_ok", d_data_ok, 1'b1);
      tick();
      m_data_ok   = 1'b0;
      d_req_valid = 1'b0;
      tick();

      // Reset in DATA clears outputs at once; fetch then regranted.
      i_req_valid = 1'b1;
      i_req_addr  = 64'h8000_0000;
      tick();
      m_addr_ok = 1'b1;
      tick();
      m_addr_ok = 1'b0;
      m_data_ok = 1'b1;
      m_rdata   = 64'h1234_5678_9ABC_DEF0;
      #1;
      reset = 1'b1;
      #1;
      chk("ar_i_data_ok", i_data_ok, 1'b0);
      chk("ar_i_data", i_data, 32'h0);
      chk("ar_m_req_addr", m_req_addr, 64'h0);
      chk("ar_m_req_size", m_req_size, 3'd0);
      tick();
      m_data_ok = 1'b0;
      reset     = 1'b0;
      #1;
      run_txn("post_rst", 1'b1, 64'h8000_0000, 64'hDEAD_BEEF_CAFE_F00D);
      i_req_valid = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
